// File: rtl/onehot_scan_decoder_if.sv
// Control/status bundle for onehot_scan_decoder: the master drives the
// enable, mode, load and dwell controls, and the slave returns the decode and its status pulses.
interface onehot_scan_decoder_if #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DIV_W   = 16
);
  logic               en;
  logic               mode;
  logic               load;
  logic [SEL_W-1:0]   sel;
  logic [DIV_W-1:0]   div;
  logic [NUM_OUT-1:0] out;
  logic [SEL_W-1:0]   idx;
  logic               wrap;
  logic               err;

  modport master (
    output en, mode, load, sel, div,
    input  out, idx, wrap, err
  );

  modport slave (
    input  en, mode, load, sel, div,
    output out, idx, wrap, err
  );
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder that can be loaded with an index directly or
// left to auto-scan through its outputs, dwelling div+1 clocks on each one.
module onehot_scan_decoder #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DIV_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_scan_decoder_if.slave  bus
);

  localparam logic [SEL_W:0]   NUM_OUT_W = NUM_OUT[SEL_W:0];
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT - 1);

  logic [SEL_W-1:0]   idx_q,  idx_d;
  logic [DIV_W-1:0]   pcnt_q, pcnt_d;
  logic [NUM_OUT-1:0] out_q,  out_d;
  logic               wrap_q, wrap_d;
  logic               err_q,  err_d;
  logic               mode_q;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    idx_d  = idx_q;
    pcnt_d = pcnt_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (bus.en) begin
      if (bus.load) begin
        if ({1'b0, bus.sel} < NUM_OUT_W) begin
          idx_d  = bus.sel;
          pcnt_d = '0;
        end else begin
          err_d  = 1'b1;
        end
      end else if (!bus.mode || !mode_q) begin
        // Direct mode parks the prescaler; entering scan restarts a full dwell.
        pcnt_d = '0;
      end else if (pcnt_q >= bus.div) begin
        pcnt_d = '0;
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d  = idx_q + SEL_W'(1);
        end
      end else begin
        pcnt_d = pcnt_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      out_d[i] = bus.en && (idx_d == SEL_W'(i));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      pcnt_q <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      pcnt_q <= pcnt_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
      mode_q <= bus.mode;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder: an 8-output instance for decode and scan behaviour,
// plus a 6-output instance for out-of-range load rejection.
module tb_onehot_scan_decoder;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder_if #(.SEL_W(3), .NUM_OUT(8), .DIV_W(16)) bus8 ();
  onehot_scan_decoder_if #(.SEL_W(3), .NUM_OUT(6), .DIV_W(16)) bus6 ();

  onehot_scan_decoder #(.SEL_W(3), .NUM_OUT(8), .DIV_W(16)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  onehot_scan_decoder #(.SEL_W(3), .NUM_OUT(6), .DIV_W(16)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6.slave)
  );

  // Outputs are sampled 1 time unit after the rising edge; inputs change at that same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect8(string name, logic [2:0] exp_idx, logic [7:0] exp_out, logic exp_wrap);
    vectors++;
    if (bus8.idx !== exp_idx || bus8.out !== exp_out || bus8.wrap !== exp_wrap || bus8.err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: idx=%0d out=%b wrap=%b err=%b, required idx=%0d out=%b wrap=%b err=0",
               name, bus8.idx, bus8.out, bus8.wrap, bus8.err, exp_idx, exp_out, exp_wrap);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.en = 1'b0; bus8.mode = 1'b0; bus8.load = 1'b0; bus8.sel = '0; bus8.div = '0;
    bus6.en = 1'b0; bus6.mode = 1'b0; bus6.load = 1'b0; bus6.sel = '0; bus6.div = '0;
    #3;
    expect8("reset_dut8", 3'd0, 8'h00, 1'b0);
    vectors++;
    if (bus6.idx !== 3'd0 || bus6.out !== 6'd0 || bus6.wrap !== 1'b0 || bus6.err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dut6: idx=%0d out=%b wrap=%b err=%b, required all zero",
               bus6.idx, bus6.out, bus6.wrap, bus6.err);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_direct();
    bus8.en = 1'b1; bus8.mode = 1'b0;
    bus8.load = 1'b1; bus8.sel = 3'd5;
    tick();
    bus8.load = 1'b0;
    expect8("direct_sel5", 3'd5, 8'b0010_0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus8.load = 1'b1; bus8.sel = 3'(i);
      tick();
      bus8.load = 1'b0;
      expect8($sformatf("direct_sweep%0d", i), 3'(i), 8'(1) << i, 1'b0);
    end
    // Without a load, direct mode holds its index.
    bus8.div = 16'd0;
    repeat (3) tick();
    expect8("direct_hold", 3'd7, 8'b1000_0000, 1'b0);
  endtask

  task automatic test_range_reject();
    bus6.en = 1'b1; bus6.mode = 1'b0;
    bus6.load = 1'b1; bus6.sel = 3'd2;
    tick();
    bus6.load = 1'b1; bus6.sel = 3'd7;
    vectors++;
    if (bus6.idx !== 3'd2 || bus6.out !== 6'b000100 || bus6.err !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_setup: idx=%0d out=%b err=%b, required idx=2 out=000100 err=0",
               bus6.idx, bus6.out, bus6.err);
    end
    tick();
    bus6.load = 1'b0;
    vectors++;
    if (bus6.idx !== 3'd2 || bus6.out !== 6'b000100 || bus6.err !== 1'b1) begin
      miscompares++;
      $display("FAIL reject_sel7: idx=%0d out=%b err=%b, required idx=2 out=000100 err=1",
               bus6.idx, bus6.out, bus6.err);
    end
    tick();
    vectors++;
    if (bus6.idx !== 3'd2 || bus6.err !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_err_clear: idx=%0d err=%b, required idx=2 err=0", bus6.idx, bus6.err);
    end
    bus6.en = 1'b0;
  endtask

  task automatic test_scan_wrap();
    int wraps;
    wraps = 0;
    bus8.en = 1'b1; bus8.mode = 1'b1; bus8.div = 16'd2;
    bus8.load = 1'b1; bus8.sel = 3'd0;
    tick();
    bus8.load = 1'b0;
    expect8("scan_k0", 3'd0, 8'b0000_0001, 1'b0);
    // Cycle k after the load edge shows output (k/3)%8; wrap only where k is a multiple of 24.
    for (int k = 1; k <= 48; k++) begin
      tick();
      if (bus8.wrap === 1'b1) wraps++;
      expect8($sformatf("scan_k%0d", k), 3'((k / 3) % 8), 8'(1) << ((k / 3) % 8),
              (k % 24) == 0);
    end
    vectors++;
    if (wraps != 2) begin
      miscompares++;
      $display("FAIL scan_wrap_count: saw %0d wrap pulses, required 2", wraps);
    end
  endtask

  task automatic test_collision();
    bus8.div = 16'd0;
    bus8.load = 1'b1; bus8.sel = 3'd6;
    tick();
    bus8.load = 1'b0;
    expect8("collide_load6", 3'd6, 8'b0100_0000, 1'b0);
    tick();
    expect8("collide_at7", 3'd7, 8'b1000_0000, 1'b0);
    bus8.load = 1'b1; bus8.sel = 3'd3;
    tick();
    bus8.load = 1'b0;
    expect8("collide_load_wins", 3'd3, 8'b0000_1000, 1'b0);
    tick();
    expect8("collide_next", 3'd4, 8'b0001_0000, 1'b0);
  endtask

  task automatic test_div_lowered();
    bus8.div = 16'd5;
    bus8.load = 1'b1; bus8.sel = 3'd1;
    tick();
    bus8.load = 1'b0;
    repeat (3) tick();
    expect8("divlow_pcnt3", 3'd1, 8'b0000_0010, 1'b0);
    // pcnt=3 now exceeds div=1, so the next edge is terminal.
    bus8.div = 16'd1;
    tick();
    expect8("divlow_advance", 3'd2, 8'b0000_0100, 1'b0);
    tick();
    expect8("divlow_dwell", 3'd2, 8'b0000_0100, 1'b0);
    tick();
    expect8("divlow_next", 3'd3, 8'b0000_1000, 1'b0);
  endtask

  task automatic test_enable_freeze();
    bus8.div = 16'd3;
    bus8.load = 1'b1; bus8.sel = 3'd4;
    tick();
    bus8.load = 1'b0;
    tick();
    bus8.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus8.load = (i == 2);
      bus8.sel  = 3'd1;
      tick();
      expect8($sformatf("freeze_%0d", i), 3'd4, 8'h00, 1'b0);
    end
    bus8.load = 1'b0;
    bus8.en = 1'b1;
    tick();
    expect8("freeze_resume_p2", 3'd4, 8'b0001_0000, 1'b0);
    tick();
    expect8("freeze_resume_p3", 3'd4, 8'b0001_0000, 1'b0);
    tick();
    expect8("freeze_resume_adv", 3'd5, 8'b0010_0000, 1'b0);
  endtask

  task automatic test_mode_change();
    bus8.mode = 1'b0; bus8.div = 16'd1;
    repeat (4) tick();
    expect8("mode_direct_freeze", 3'd5, 8'b0010_0000, 1'b0);
    bus8.mode = 1'b1;
    tick();
    expect8("mode_enter_a", 3'd5, 8'b0010_0000, 1'b0);
    tick();
    expect8("mode_enter_b", 3'd5, 8'b0010_0000, 1'b0);
    tick();
    expect8("mode_enter_adv", 3'd6, 8'b0100_0000, 1'b0);
  endtask

  task automatic test_async_reset();
    bus8.div = 16'd1;
    bus8.load = 1'b1; bus8.sel = 3'd6;
    tick();
    bus8.load = 1'b0;
    expect8("areset_pre", 3'd6, 8'b0100_0000, 1'b0);
    #1 rst = 1'b1;
    #1;
    expect8("areset_mid", 3'd0, 8'h00, 1'b0);
    #1 rst = 1'b0;
    tick();
    expect8("areset_first", 3'd0, 8'b0000_0001, 1'b0);
    tick();
    expect8("areset_dwell", 3'd0, 8'b0000_0001, 1'b0);
    tick();
    expect8("areset_adv", 3'd1, 8'b0000_0010, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_direct();
    test_range_reject();
    test_scan_wrap();
    test_collision();
    test_div_lowered();
    test_enable_freeze();
    test_mode_change();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
